// File: rtl/mipi_rx_pkg.sv
// Shared constants and state encoding for the CSI-2 receive lane aligner.
// Imported by the aligner top and its per-lane delay line.
package mipi_rx_pkg;

    localparam int BYTE_W          = 8;
    localparam int ALIGN_DEPTH_DEF = 8;
    localparam int CNT_W           = $clog2(ALIGN_DEPTH_DEF);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SKEW      = 2'd1,
        ST_LOCKED    = 2'd2,
        ST_WAIT_IDLE = 2'd3
    } align_state_e;

    // Width of the skew counter, offsets and taps for a given skew window.
    function automatic int cnt_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mipi_rx_lane_delay.sv
// One lane's free-running {valid, byte} delay line with a variable tap.
// The tapped valid is presented combinationally; the tapped byte is registered on load.
module mipi_rx_lane_delay
    import mipi_rx_pkg::*;
#(
    parameter int ALIGN_DEPTH = 8
) (
    input  logic                           clk_i,
    input  logic                           reset_in,
    input  logic                           valid_i,
    input  logic [BYTE_W-1:0]              byte_i,
    input  logic [$clog2(ALIGN_DEPTH)-1:0] tap_i,
    input  logic                           load_i,
    output logic                           dly_valid_o,
    output logic [BYTE_W-1:0]              byte_o
);

    // Stage 0 is the input registered once; together with the live input this
    // gives ALIGN_DEPTH+1 observable positions, of which the tap reads stages 0..ALIGN_DEPTH-1.
    logic              valid_q [ALIGN_DEPTH];
    logic [BYTE_W-1:0] data_q  [ALIGN_DEPTH];
    logic [BYTE_W-1:0] byte_q;

    always_ff @(posedge clk_i) begin
        if (!reset_in) begin
            for (int i = 0; i < ALIGN_DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                data_q[i]  <= '0;
            end
            byte_q <= '0;
        end else begin
            valid_q[0] <= valid_i;
            data_q[0]  <= byte_i;
            for (int i = 1; i < ALIGN_DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
            if (load_i) begin
                byte_q <= data_q[tap_i];
            end
        end
    end

    assign dly_valid_o = valid_q[tap_i];
    assign byte_o      = byte_q;

endmodule

// File: rtl/mipi_rx_lane_aligner_n.sv
// De-skews up to LANES byte-aligned CSI-2 lanes by measuring each lane's valid-rise
// offset within a bounded window and delaying the early lanes to match the latest one.
module mipi_rx_lane_aligner_n
    import mipi_rx_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int ALIGN_DEPTH = 8
) (
    input  logic                           clk_i,
    input  logic                           reset_in,
    input  logic [$clog2(LANES+1)-1:0]     active_lanes_i,
    input  logic [LANES-1:0]               bytes_valid_i,
    input  logic [BYTE_W*LANES-1:0]        byte_i,
    output logic                           lane_valid_o,
    output logic [BYTE_W*LANES-1:0]        lane_byte_o,
    output logic                           align_err_o,
    output logic [$clog2(ALIGN_DEPTH)-1:0] skew_o
);

    localparam int CW = cnt_width(ALIGN_DEPTH);

    // Interface semantics: valid-only streaming, no backpressure. A lane byte is
    // meaningful exactly in cycles where its valid is 1; lane_valid_o marks cycles
    // where every active lane's byte of the same index is present on lane_byte_o.

    align_state_e                state_q, state_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [LANES-1:0]            seen_q, seen_d;
    logic [LANES-1:0][CW-1:0]    off_q, off_d;
    logic [LANES-1:0][CW-1:0]    tap_q, tap_d;
    logic [CW-1:0]               skew_q, skew_d;
    logic                        err_q, err_d;
    logic                        valid_q, valid_d;
    logic [LANES-1:0]            act_q, act_d;

    logic [LANES-1:0]            req_mask;
    logic [LANES-1:0]            act_mask;
    logic [LANES-1:0]            vin;
    logic [LANES-1:0]            rises;
    logic [LANES-1:0]            dly_valid;
    logic [LANES-1:0]            lane_load;
    logic [LANES-1:0][BYTE_W-1:0] lane_q;
    logic                        all_dv;
    logic                        load;

    // Zero or an out-of-range count selects every physical lane.
    always_comb begin
        req_mask = '0;
        if (active_lanes_i == '0 || int'(active_lanes_i) > LANES) begin
            req_mask = '1;
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (l < int'(active_lanes_i)) begin
                    req_mask[l] = 1'b1;
                end
            end
        end
    end

    assign act_mask = (state_q == ST_IDLE) ? req_mask : act_q;
    assign vin      = bytes_valid_i & act_mask;
    assign rises    = vin & ~seen_q;

    always_comb begin
        all_dv = 1'b1;
        for (int l = 0; l < LANES; l++) begin
            if (act_q[l] && !dly_valid[l]) begin
                all_dv = 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        seen_d  = seen_q;
        off_d   = off_q;
        tap_d   = tap_q;
        skew_d  = skew_q;
        err_d   = 1'b0;
        valid_d = 1'b0;
        act_d   = act_q;
        load    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                act_d  = req_mask;
                seen_d = vin;
                off_d  = '0;
                cnt_d  = CW'(1);
                if (vin != '0) begin
                    if (vin == req_mask) begin
                        state_d = ST_LOCKED;
                        tap_d   = '0;
                        skew_d  = '0;
                    end else begin
                        state_d = ST_SKEW;
                    end
                end
            end

            ST_SKEW: begin
                seen_d = seen_q | rises;
                for (int l = 0; l < LANES; l++) begin
                    if (rises[l]) begin
                        off_d[l] = cnt_q;
                    end
                end
                if (seen_d == act_q) begin
                    // Taps are ready before the first locked cycle so that cycle's read is aligned.
                    state_d = ST_LOCKED;
                    skew_d  = cnt_q;
                    for (int l = 0; l < LANES; l++) begin
                        tap_d[l] = act_q[l] ? (cnt_q - off_d[l]) : '0;
                    end
                end else if ((seen_q & ~bytes_valid_i) != '0) begin
                    err_d   = 1'b1;
                    state_d = ST_WAIT_IDLE;
                end else if (cnt_q == CW'(ALIGN_DEPTH-1)) begin
                    err_d   = 1'b1;
                    state_d = ST_WAIT_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_LOCKED: begin
                // The aligned word must be present from the first locked cycle; any gap ends the packet.
                if (all_dv) begin
                    valid_d = 1'b1;
                    load    = 1'b1;
                end else begin
                    state_d = ST_WAIT_IDLE;
                end
            end

            ST_WAIT_IDLE: begin
                if (vin == '0) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_WAIT_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_in) begin
            state_q <= ST_WAIT_IDLE;
            cnt_q   <= '0;
            seen_q  <= '0;
            off_q   <= '0;
            tap_q   <= '0;
            skew_q  <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            act_q   <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
            off_q   <= off_d;
            tap_q   <= tap_d;
            skew_q  <= skew_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            act_q   <= act_d;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_load[l] = load & act_q[l];

        mipi_rx_lane_delay #(
            .ALIGN_DEPTH(ALIGN_DEPTH)
        ) u_delay (
            .clk_i       (clk_i),
            .reset_in    (reset_in),
            .valid_i     (bytes_valid_i[l]),
            .byte_i      (byte_i[BYTE_W*l +: BYTE_W]),
            .tap_i       (tap_q[l]),
            .load_i      (lane_load[l]),
            .dly_valid_o (dly_valid[l]),
            .byte_o      (lane_q[l])
        );
    end

    always_comb begin
        lane_byte_o = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_byte_o[BYTE_W*l +: BYTE_W] = act_q[l] ? lane_q[l] : '0;
        end
    end

    assign lane_valid_o = valid_q;
    assign align_err_o  = err_q;
    assign skew_o       = skew_q;

endmodule

// File: tb/tb_mipi_rx_lane_aligner_n.sv
// Directed bench for the 4-lane, 8-deep lane aligner: a vector table of per-cycle
// inputs and expected outputs, plus a hand-written reset-while-locked sequence.
module tb_mipi_rx_lane_aligner_n;

    logic        clk;
    logic        reset_n;
    logic [2:0]  active_lanes;
    logic [3:0]  bytes_valid;
    logic [31:0] byte_in;
    logic        lane_valid;
    logic [31:0] lane_byte;
    logic        align_err;
    logic [2:0]  skew;

    mipi_rx_lane_aligner_n #(
        .LANES      (4),
        .ALIGN_DEPTH(8)
    ) dut (
        .clk_i          (clk),
        .reset_in       (reset_n),
        .active_lanes_i (active_lanes),
        .bytes_valid_i  (bytes_valid),
        .byte_i         (byte_in),
        .lane_valid_o   (lane_valid),
        .lane_byte_o    (lane_byte),
        .align_err_o    (align_err),
        .skew_o         (skew)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  act;
        logic [3:0]  v;
        logic [31:0] b;
        logic        ev;
        logic        ee;
        logic        cb;
        logic [31:0] eb;
        logic [2:0]  es;
    } vec_t;

    vec_t       tbl[$];
    logic [2:0] cur_skew;
    int         n_checks;
    int         n_fail;

    // Apply one cycle of inputs, then sample outputs 1 time unit after the edge.
    task automatic step(input logic rst, input logic [2:0] act, input logic [3:0] v,
                        input logic [31:0] b);
        reset_n      = rst;
        active_lanes = act;
        bytes_valid  = v;
        byte_in      = b;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // A row with no lock expected: lane_valid 0, byte check optional (expects 0).
    task automatic push_raw(input logic [2:0] act, input logic [3:0] v, input logic ee,
                            input logic cb);
        vec_t rv;
        rv.act = act;
        rv.v   = v;
        rv.b   = 32'h6162_6364;
        rv.ev  = 1'b0;
        rv.ee  = ee;
        rv.cb  = cb;
        rv.eb  = '0;
        rv.es  = cur_skew;
        tbl.push_back(rv);
    endtask

    // Rows for one packet that must lock. Lane l byte k = base + lstep*l + k.
    // With last rise at relative cycle m: words at rows m+1..m+len, idle again by row m+len+2.
    task automatic gen_lock(input int act_n, input int act_late, input int o0, input int o1,
                            input int o2, input int o3, input int len, input logic [7:0] base,
                            input logic [7:0] lstep, input bit garb);
        vec_t rv;
        int   offs[4];
        int   n;
        int   m;
        int   k;
        offs = '{o0, o1, o2, o3};
        n = (act_n == 0 || act_n > 4) ? 4 : act_n;
        m = 0;
        for (int l = 0; l < n; l++) if (offs[l] > m) m = offs[l];
        for (int r = 0; r <= m + len + 2; r++) begin
            rv.act = 3'((r == 0) ? act_n : act_late);
            rv.v   = '0;
            rv.b   = '0;
            rv.eb  = '0;
            for (int l = 0; l < 4; l++) begin
                if (l < n) begin
                    if (r >= offs[l] && r < offs[l] + len) begin
                        rv.v[l] = 1'b1;
                        rv.b[8*l +: 8] = 8'(int'(base) + int'(lstep) * l + r - offs[l]);
                    end else begin
                        rv.b[8*l +: 8] = 8'hEE;
                    end
                end else if (garb && r < m + len) begin
                    rv.v[l] = ((r + l) % 3 != 0);
                    rv.b[8*l +: 8] = 8'(8'hC0 + r);
                end
            end
            k = (r <= m + len) ? r - m - 1 : len - 1;
            for (int l = 0; l < n; l++) begin
                rv.eb[8*l +: 8] = 8'(int'(base) + int'(lstep) * l + k);
            end
            rv.ev = (r >= m + 1 && r <= m + len);
            rv.cb = (r >= m + 1);
            rv.ee = 1'b0;
            rv.es = (r >= m) ? 3'(m) : cur_skew;
            tbl.push_back(rv);
        end
        cur_skew = 3'(m);
    endtask

    logic [3:0]  sv;
    logic [31:0] sb;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cur_skew = '0;

        // Reset state
        step(1'b0, 3'd4, 4'h0, 32'h0);
        step(1'b0, 3'd4, 4'hF, 32'hFFFF_FFFF);
        check("reset_valid", 32'(lane_valid), 32'h0);
        check("reset_bytes", lane_byte, 32'h0);
        check("reset_err", 32'(align_err), 32'h0);
        check("reset_skew", 32'(skew), 32'h0);

        // Leave WAIT_IDLE after reset
        push_raw(3'd4, 4'h0, 1'b0, 1'b1);
        push_raw(3'd4, 4'h0, 1'b0, 1'b1);
        // All lanes together, word k = {4{0x10+k}}
        gen_lock(4, 4, 0, 0, 0, 0, 4, 8'h10, 8'h00, 1'b0);
        // Lane 2 three cycles late: skew 3, taps {3,3,0,3}
        gen_lock(4, 4, 0, 0, 3, 0, 5, 8'h40, 8'h10, 1'b0);
        // Lane 3 eight cycles late: error pulse at cnt=7, no lock
        for (int r = 0; r <= 14; r++) begin
            sv = '0;
            sv[2:0] = (r < 12) ? 3'b111 : 3'b000;
            sv[3]   = (r >= 8 && r < 14);
            push_raw(3'd4, sv, (r == 7), 1'b0);
        end
        // Maximum tolerated skew of 7 with active count 0 meaning all lanes
        gen_lock(0, 0, 0, 2, 1, 7, 9, 8'h20, 8'h20, 1'b0);
        // Two active lanes, lanes 2/3 garbage, active count raised mid-packet
        gen_lock(2, 4, 0, 1, 0, 0, 4, 8'h80, 8'h10, 1'b1);
        // Lane 0 drops during SKEW before lane 1 rises
        for (int r = 0; r <= 10; r++) begin
            sv = '0;
            sv[0] = (r < 2);
            sv[1] = (r >= 4 && r < 10);
            sv[2] = (r < 8);
            sv[3] = (r < 8);
            push_raw(3'd4, sv, (r == 2), 1'b0);
        end
        // Clean packet after the error
        gen_lock(4, 4, 1, 0, 0, 0, 3, 8'h90, 8'h08, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(1'b1, tbl[i].act, tbl[i].v, tbl[i].b);
            check($sformatf("valid[%0d]", i), 32'(lane_valid), 32'(tbl[i].ev));
            check($sformatf("err[%0d]", i), 32'(align_err), 32'(tbl[i].ee));
            check($sformatf("skew[%0d]", i), 32'(skew), 32'(tbl[i].es));
            if (tbl[i].cb) begin
                check($sformatf("bytes[%0d]", i), lane_byte, tbl[i].eb);
            end
        end

        // Reset for one cycle while locked and valids stay high; the tail must not lock
        for (int r = 0; r < 18; r++) begin
            sv = '0;
            sb = {4{8'hEE}};
            if (r < 13) begin
                for (int l = 0; l < 3; l++) begin
                    if (r < 10) begin
                        sv[l] = 1'b1;
                        sb[8*l +: 8] = 8'(8'h30 + 16 * l + r);
                    end
                end
                if (r >= 2 && r < 12) begin
                    sv[3] = 1'b1;
                    sb[31:24] = 8'(8'h60 + r - 2);
                end
            end else if (r < 16) begin
                sv = 4'hF;
                sb = {4{8'(8'h70 + r - 13)}};
            end
            step((r != 4), 3'd4, sv, sb);
            if (r == 2) check("rst_pre_skew", 32'(skew), 32'd2);
            if (r == 3) begin
                check("rst_pre_valid", 32'(lane_valid), 32'h1);
                check("rst_pre_bytes", lane_byte, 32'h6050_4030);
            end
            if (r == 4) begin
                check("rst_valid", 32'(lane_valid), 32'h0);
                check("rst_bytes", lane_byte, 32'h0);
                check("rst_err", 32'(align_err), 32'h0);
                check("rst_skew", 32'(skew), 32'h0);
            end
            if (r >= 5 && r <= 12) begin
                check($sformatf("rst_tail_valid[%0d]", r), 32'(lane_valid), 32'h0);
                check($sformatf("rst_tail_err[%0d]", r), 32'(align_err), 32'h0);
            end
            if (r == 13) check("rst_fresh_skew", 32'(skew), 32'h0);
            if (r >= 14 && r <= 16) begin
                check($sformatf("rst_fresh_valid[%0d]", r), 32'(lane_valid), 32'h1);
                check($sformatf("rst_fresh_bytes[%0d]", r), lane_byte, {4{8'(8'h70 + r - 14)}});
            end
            if (r == 17) check("rst_fresh_end", 32'(lane_valid), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mipi_rx_lane_aligner_n.md
Name: mipi_rx_lane_aligner_n

Overview:
Parametrised successor to the fixed 4-lane lane aligner. It sits between the per-lane byte aligners and the CSI packet decoder, in the byte-clock domain. It de-skews up to LANES byte-aligned lanes by measuring each lane's valid-rise offset and delaying early lanes. It adds a runtime active-lane count, a bounded skew window with error reporting, and a skew status output.

Parameters:
LANES, 4, physical lane count (1..8)
ALIGN_DEPTH, 8, skew window in byte clocks; max tolerated skew = ALIGN_DEPTH-1 (>=2)

Ports:
clk_i  in  1  byte clock
reset_in  in  1  synchronous reset, active-low
active_lanes_i  in  $clog2(LANES+1)  lanes in use (lanes 0..N-1); sampled only in IDLE; 0 or >LANES means LANES
bytes_valid_i  in  LANES  per-lane byte valid from byte aligners
byte_i  in  8*LANES  lane l on bits [8l+7:8l]
lane_valid_o  out  1  aligned word valid
lane_byte_o  out  8*LANES  de-skewed bytes; inactive lanes = 0
align_err_o  out  1  one-cycle pulse when the skew window is exceeded or a lane drops during SKEW
skew_o  out  $clog2(ALIGN_DEPTH)  max skew (cycles) of the last locked packet

Behaviour:
- Reset (reset_in=0 at a clk_i edge):
  - all outputs 0, all taps 0, state=WAIT_IDLE.
  - Reset mid-packet never locks onto a packet tail.
- Delay lines: per lane, free-running shift of {valid, byte} on every clk_i regardless of state; depth ALIGN_DEPTH+1.
- "Active" below means lanes below the active count; inactive lane valids are ignored.
- States:
  - IDLE:
    - Latch active count.
    - If any active valid=1: record offset 0 for each such lane, cnt<=1.
    - If all active valids=1 in that same cycle: go to LOCKED with skew 0.
    - Otherwise go to SKEW.
  - SKEW:
    - Each active lane whose valid rises this cycle records offset=cnt.
    - If all active lanes have now been seen: max=cnt, go to LOCKED.
    - Else if any already-seen lane's valid=0: align_err_o=1, go to WAIT_IDLE.
    - Else if cnt==ALIGN_DEPTH-1: align_err_o=1, go to WAIT_IDLE.
    - Else cnt<=cnt+1.
  - LOCKED:
    - Entry cycle registers tap_l = max - offset_l and skew_o <= max.
    - lane_valid_o <= AND over active l of delayed_valid_l[tap_l].
    - lane_byte_o lane l <= delayed_byte_l[tap_l].
    - When that AND is 0 after having been 1: go to WAIT_IDLE.
  - WAIT_IDLE: lane_valid_o=0; go to IDLE when all active valids=0.
- Latency:
  - Let T be the cycle in which the last active lane's valid rises.
  - First aligned word appears at T+2.
  - Per-lane latency = tap_l + 2 cycles.
  - Each byte index k of every lane appears in the same output word.
- Packet end:
  - lane_valid_o falls 2 cycles after the first delayed lane valid falls.
  - Unequal-length lanes truncate to the shortest.
- lane_byte_o holds its last value while lane_valid_o=0, except that inactive lanes are always 0.
- Simultaneous rises: lanes rising in the same cycle get equal offsets.
- Glitch handling: in LOCKED or WAIT_IDLE, re-rise of a lane valid is ignored until IDLE.
- active_lanes_i changes outside IDLE have no effect until the next IDLE.
- align_err_o and a lock are never asserted in the same packet.
- Width rule: cnt, offsets and taps are $clog2(ALIGN_DEPTH) bits; the cnt compare stops before wrap.

Decomposition:
- Shared package mipi_rx_pkg:
  - state encodings IDLE/SKEW/LOCKED/WAIT_IDLE
  - localparam CNT_W = $clog2(ALIGN_DEPTH)
  - byte width constant 8
- Sub-module mipi_rx_lane_delay:
  - one lane's {valid, byte} shift register with a registered variable tap read
  - instantiated LANES times via generate
- The FSM and tap computation stay in the top.

Test Plan:
- LANES=4, active=4, all valids rise together with bytes 0x10+k per lane → lane_valid_o rises 2 cycles later; skew_o=0; word k = {0x10+k ×4}.
- Lane 2 rises 3 cycles after lanes 0,1,3 → skew_o=3; taps {3,3,0,3}; first output word has byte 0 of every lane; lane_valid_o at T+2.
- Lane 3 rises 8 cycles late (ALIGN_DEPTH=8) → align_err_o single pulse at cnt=7; no lane_valid_o; returns to IDLE only after all valids low.
- active_lanes_i=2, lanes 2,3 toggling garbage → only lanes 0,1 aligned; lane_byte_o[31:16]=0; change active to 4 mid-packet → no effect until next packet.
- reset_in=0 for 1 cycle mid-LOCKED while valids stay high → outputs 0 immediately; no lock until all valids low then a fresh rise.
- Lane 0 valid drops during SKEW before lane 1 rises → align_err_o pulse; WAIT_IDLE; next clean packet locks normally.
